// File: rtl/game_countdown_timer.sv
// -----------------------------------------------------------------------------
// game_countdown_timer
//
// Parametrised BCD countdown timer that drives the game's time-left display.
// A prescaler divides ClockIn down to one count step every CLOCK_FREQUENCY
// cycles. A four-state run FSM (IDLE, RUN, PAUSED, EXPIRED) decides when the
// BCD count is allowed to move. The Expired output ends a game round in the
// game-control FSM.
//
// Parameters
//   CLOCK_FREQUENCY : ClockIn cycles per count step (>= 2)
//   NUM_DIGITS      : number of BCD digits (1..6)
//   START_VALUE     : decimal value loaded on reset (< 10**NUM_DIGITS)
//   WARN_THRESHOLD  : decimal warning level (only with TIMER_WARN_EN)
//
// Ports
//   ClockIn     in   system clock
//   Reset       in   synchronous, active-high reset
//   Start       in   level: start counting from IDLE, or resume from PAUSED
//   Pause       in   level: freeze counting while running
//   Load        in   level: load LoadValue (digits > 9 clamp to 9), go idle
//   LoadValue   in   BCD value to load, digit 0 in [3:0]
//   Count       out  registered BCD time remaining, digit 0 in [3:0]
//   Running     out  high while in RUN
//   Expired     out  high while in EXPIRED
//   ExpirePulse out  one-cycle pulse on entry to EXPIRED
//   SecondTick  out  one-cycle pulse in the cycle Count shows a decremented value
//   Warn        out  low-time warning flag
//
// Optional feature macro: TIMER_WARN_EN
//   Defined   : Warn is a registered flag. It is high in RUN or PAUSED while
//               Count <= WARN_THRESHOLD.
//   Undefined : Warn is tied low and no comparator is built.
//
// Control priority each cycle: Reset > Load > Pause > Start.
// -----------------------------------------------------------------------------
module game_countdown_timer #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int NUM_DIGITS      = 2,
    parameter int START_VALUE     = 60,
    parameter int WARN_THRESHOLD  = 10
) (
    input  logic                      ClockIn,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic                      Pause,
    input  logic                      Load,
    input  logic [4*NUM_DIGITS-1:0]   LoadValue,
    output logic [4*NUM_DIGITS-1:0]   Count,
    output logic                      Running,
    output logic                      Expired,
    output logic                      ExpirePulse,
    output logic                      SecondTick,
    output logic                      Warn
);

    localparam int CW = 4 * NUM_DIGITS;
    localparam int DW = $clog2(CLOCK_FREQUENCY);

    localparam logic [DW-1:0] DIV_RELOAD = DW'(CLOCK_FREQUENCY - 1);
    localparam logic [CW-1:0] ZERO_BCD   = {CW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Convert a decimal constant into packed BCD. Used only at elaboration.
    function automatic logic [CW-1:0] to_bcd(input int value);
        logic [CW-1:0] result;
        int            rem;
        result = {CW{1'b0}};
        rem    = value;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            result[4*i +: 4] = 4'(rem % 10);
            rem              = rem / 10;
        end
        return result;
    endfunction

    // Force any non-decimal nibble (A..F) down to 9.
    function automatic logic [CW-1:0] bcd_clamp(input logic [CW-1:0] value);
        logic [CW-1:0] result;
        result = value;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (value[4*i +: 4] > 4'd9) begin
                result[4*i +: 4] = 4'd9;
            end else begin
                result[4*i +: 4] = value[4*i +: 4];
            end
        end
        return result;
    endfunction

    // Subtract one from a valid BCD number. The borrow ripples upward: a 0
    // digit wraps to 9 and keeps borrowing, and the first nonzero digit
    // absorbs the borrow.
    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] value);
        logic [CW-1:0] result;
        logic          borrow;
        result = value;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (value[4*i +: 4] == 4'd0) begin
                    result[4*i +: 4] = 4'd9;
                    borrow           = 1'b1;
                end else begin
                    result[4*i +: 4] = value[4*i +: 4] - 4'd1;
                    borrow           = 1'b0;
                end
            end else begin
                result[4*i +: 4] = value[4*i +: 4];
            end
        end
        return result;
    endfunction

    localparam logic [CW-1:0] START_BCD = to_bcd(START_VALUE);

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DW-1:0]   div_q, div_d;
    logic            running_q, running_d;
    logic            expired_q, expired_d;
    logic            pulse_q, pulse_d;
    logic            tick_q, tick_d;

    logic            count_zero_s;
    logic            div_zero_s;
    logic [CW-1:0]   count_dec_s;
    logic [CW-1:0]   load_clamped_s;
    logic            go_s;

    assign count_zero_s   = (count_q == ZERO_BCD);
    assign div_zero_s     = (div_q == {DW{1'b0}});
    assign count_dec_s    = bcd_dec(count_q);
    assign load_clamped_s = bcd_clamp(LoadValue);
    // Pause outranks Start, so a simultaneous Pause masks Start in every state.
    assign go_s           = Start & ~Pause;

    // Next-state, divider and count logic for the run FSM.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        div_d   = div_q;
        tick_d  = 1'b0;
        pulse_d = 1'b0;

        if (Load) begin
            // Loading aborts any second in progress. No tick or pulse is issued.
            state_d = ST_IDLE;
            count_d = load_clamped_s;
            div_d   = DIV_RELOAD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go_s) begin
                        // Reload so the first step lands a full period after Start.
                        div_d = DIV_RELOAD;
                        if (count_zero_s) begin
                            state_d = ST_EXPIRED;
                            pulse_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                ST_RUN: begin
                    if (Pause) begin
                        // Freeze the divider as-is (even at 0) so no partial
                        // second is lost or double-counted on resume.
                        state_d = ST_PAUSED;
                    end else if (div_zero_s) begin
                        div_d   = DIV_RELOAD;
                        count_d = count_dec_s;
                        tick_d  = 1'b1;
                        if (count_dec_s == ZERO_BCD) begin
                            state_d = ST_EXPIRED;
                            pulse_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        div_d = div_q - DW'(1'b1);
                    end
                end

                ST_PAUSED: begin
                    if (go_s) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSED;
                    end
                end

                ST_EXPIRED: begin
                    // Only Load or Reset leaves this state.
                    state_d = ST_EXPIRED;
                    count_d = ZERO_BCD;
                end

                default: begin
                    state_d = ST_IDLE;
                    count_d = START_BCD;
                    div_d   = DIV_RELOAD;
                end
            endcase
        end

        // Status flags follow the next state so they line up with Count.
        running_d = (state_d == ST_RUN);
        expired_d = (state_d == ST_EXPIRED);
    end

    // State, counter and status register bank with synchronous reset.
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            count_q   <= START_BCD;
            div_q     <= DIV_RELOAD;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            pulse_q   <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            div_q     <= div_d;
            running_q <= running_d;
            expired_q <= expired_d;
            pulse_q   <= pulse_d;
            tick_q    <= tick_d;
        end
    end

    assign Count       = count_q;
    assign Running     = running_q;
    assign Expired     = expired_q;
    assign ExpirePulse = pulse_q;
    assign SecondTick  = tick_q;

    // -------------------------------------------------------------------------
    // Optional low-time warning
    // -------------------------------------------------------------------------
`ifdef TIMER_WARN_EN
    localparam int MAX_VALUE  = (10 ** NUM_DIGITS) - 1;
    localparam int WARN_LEVEL = (WARN_THRESHOLD > MAX_VALUE) ? MAX_VALUE : WARN_THRESHOLD;
    // Valid BCD orders the same way as its unsigned bit pattern, so the
    // threshold test works directly on the digits.
    localparam logic [CW-1:0] WARN_BCD = to_bcd(WARN_LEVEL);

    logic warn_q, warn_d;

    // Warning is active only while a round is live (running or paused).
    always_comb begin
        warn_d = 1'b0;
        if ((state_d == ST_RUN) || (state_d == ST_PAUSED)) begin
            warn_d = (count_d <= WARN_BCD);
        end else begin
            warn_d = 1'b0;
        end
    end

    // Warning flag register.
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= warn_d;
        end
    end

    assign Warn = warn_q;
`else
    assign Warn = 1'b0;
`endif

endmodule

// File: tb/tb_game_countdown_timer.sv
module tb_game_countdown_timer;

    localparam int CF = 4;
    localparam int ND = 2;
    localparam int SV = 60;
    localparam int WT = 10;
    localparam int LW = 4 * ND;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_EXP    = 3;

    logic          ClockIn = 1'b0;
    logic          Reset = 1'b0;
    logic          Start = 1'b0;
    logic          Pause = 1'b0;
    logic          Load = 1'b0;
    logic [LW-1:0] LoadValue = '0;
    logic [LW-1:0] Count;
    logic          Running, Expired, ExpirePulse, SecondTick, Warn;

    game_countdown_timer #(
        .CLOCK_FREQUENCY(CF),
        .NUM_DIGITS     (ND),
        .START_VALUE    (SV),
        .WARN_THRESHOLD (WT)
    ) dut (
        .ClockIn    (ClockIn),
        .Reset      (Reset),
        .Start      (Start),
        .Pause      (Pause),
        .Load       (Load),
        .LoadValue  (LoadValue),
        .Count      (Count),
        .Running    (Running),
        .Expired    (Expired),
        .ExpirePulse(ExpirePulse),
        .SecondTick (SecondTick),
        .Warn       (Warn)
    );

    always #5 ClockIn = ~ClockIn;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model (decimal value, elapsed cycles) -----
    typedef struct {
        int val;
        int mode;
        int elapsed;
        bit tick;
        bit pulse;
    } mstate_t;

    mstate_t m;
    bit      m_valid = 1'b0;

    function automatic int clamp_dec(input logic [LW-1:0] v);
        int r = 0;
        int w = 1;
        int d;
        for (int i = 0; i < ND; i++) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            r = r + d * w;
            w = w * 10;
        end
        return r;
    endfunction

    function automatic logic [LW-1:0] dec_to_bcd(input int v);
        logic [LW-1:0] r = '0;
        int x = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input bit rst, input bit ld,
                                           input logic [LW-1:0] lv, input bit pa, input bit st);
        mstate_t n = s;
        n.tick  = 1'b0;
        n.pulse = 1'b0;
        if (rst) begin
            n.val = SV; n.mode = M_IDLE; n.elapsed = 0;
        end else if (ld) begin
            n.val = clamp_dec(lv); n.mode = M_IDLE; n.elapsed = 0;
        end else begin
            case (s.mode)
                M_IDLE: if (st && !pa) begin
                    n.elapsed = 0;
                    if (s.val == 0) begin n.mode = M_EXP; n.pulse = 1'b1; end
                    else n.mode = M_RUN;
                end
                M_RUN: if (pa) n.mode = M_PAUSED;
                    else if (s.elapsed == CF - 1) begin
                        n.elapsed = 0;
                        n.val     = s.val - 1;
                        n.tick    = 1'b1;
                        if (n.val == 0) begin n.mode = M_EXP; n.pulse = 1'b1; end
                    end else n.elapsed = s.elapsed + 1;
                M_PAUSED: if (st && !pa) n.mode = M_RUN;
                default: n.val = 0;
            endcase
        end
        return n;
    endfunction

    always @(posedge ClockIn) begin
        m <= model_next(m, Reset, Load, LoadValue, Pause, Start);
        if (Reset) m_valid <= 1'b1;
    end

    function automatic bit exp_warn(input mstate_t s);
`ifdef TIMER_WARN_EN
        return ((s.mode == M_RUN) || (s.mode == M_PAUSED)) && (s.val <= WT);
`else
        return 1'b0;
`endif
    endfunction

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge ClockIn) begin
        if (m_valid) begin
            check("count",   32'(Count),       32'(dec_to_bcd(m.val)));
            check("running", 32'(Running),     32'(m.mode == M_RUN));
            check("expired", 32'(Expired),     32'(m.mode == M_EXP));
            check("pulse",   32'(ExpirePulse), 32'(m.pulse));
            check("tick",    32'(SecondTick),  32'(m.tick));
            check("warn",    32'(Warn),        32'(exp_warn(m)));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge ClockIn);
        #1;
    endtask

    task automatic do_load(input logic [LW-1:0] v);
        Load = 1'b1; LoadValue = v;
        cyc(1);
        Load = 1'b0;
    endtask

    task automatic do_start();
        Start = 1'b1;
        cyc(1);
        Start = 1'b0;
    endtask

    // ---------------- directed literal expectations + random run -----------
    initial begin
        Reset = 1'b1;
        cyc(2);
        Reset = 1'b0;
        check("rst_count", 32'(Count), 32'h60);
        check("rst_flags", {Running, Expired, ExpirePulse, SecondTick, Warn}, 32'h0);

        // First second takes exactly CF cycles after the Start cycle.
        do_start();
        check("run_start", {Running, Count}, 32'h160);
        cyc(3);
        check("hold60", {SecondTick, Count}, 32'h060);
        cyc(1);
        check("first_step", {SecondTick, Count}, 32'h159);
        cyc(1);
        check("tick_one_cycle", {SecondTick, Count}, 32'h059);
        cyc(3);
        check("second_step", {SecondTick, Count}, 32'h158);

        // Borrow and expiry.
        do_load(8'h10);
        check("load10", {Running, Count}, 32'h010);
        do_start();
        cyc(4);
        check("borrow", {SecondTick, Count}, 32'h109);
        cyc(32);
        check("at01", {Expired, Count}, 32'h001);
        cyc(4);
        check("expire", {Running, Expired, ExpirePulse, SecondTick, Count}, 32'h700);
        cyc(1);
        check("pulse_once", {Expired, ExpirePulse}, 32'h2);
        do_start();
        check("exp_ignores_start", {Running, Expired, Count}, 32'h100);

        // Pause two cycles into a second; nothing is lost on resume.
        do_load(8'h60);
        do_start();
        cyc(4);
        check("p_step", 32'(Count), 32'h59);
        cyc(2);
        Pause = 1'b1;
        cyc(1);
        check("paused", 32'(Running), 32'h0);
        cyc(19);
        check("pause_hold", {Running, Count}, 32'h059);
        Pause = 1'b0;
        do_start();
        check("resume", {Running, Count}, 32'h159);
        cyc(1);
        check("resume_wait", {SecondTick, Count}, 32'h059);
        cyc(1);
        check("resume_step", {SecondTick, Count}, 32'h158);

        // Pause coinciding with a step: no decrement, step on first RUN cycle.
        do_load(8'h05);
        do_start();
        cyc(3);
        Pause = 1'b1;
        cyc(1);
        check("pause_wins", {Running, SecondTick, Count}, 32'h005);
        cyc(2);
        Pause = 1'b0;
        do_start();
        check("resume0", {Running, Count}, 32'h105);
`ifdef TIMER_WARN_EN
        check("warn_low", 32'(Warn), 32'h1);
`else
        check("warn_tied", 32'(Warn), 32'h0);
`endif
        cyc(1);
        check("resume0_step", {SecondTick, Count}, 32'h104);

        // Clamp, and Load over Start.
        do_load(8'hAF);
        check("clamp", {Running, Count}, 32'h099);
        Start = 1'b1; Load = 1'b1; LoadValue = 8'h25;
        cyc(1);
        Start = 1'b0; Load = 1'b0;
        check("load_wins", {Running, Count}, 32'h025);

        // Start at zero expires next cycle.
        do_load(8'h00);
        do_start();
        check("zero_start", {Running, Expired, ExpirePulse, Count}, 32'h300);
        cyc(1);
        check("zero_pulse_off", {Expired, ExpirePulse}, 32'h2);

        // Reset mid-run.
        do_load(8'h30);
        do_start();
        cyc(6);
        Reset = 1'b1;
        cyc(1);
        Reset = 1'b0;
        check("rst_mid", {Running, Expired, ExpirePulse, SecondTick, Count}, 32'h060);

`ifdef TIMER_WARN_EN
        do_load(8'h12);
        do_start();
        check("w12", 32'(Warn), 32'h0);
        cyc(4);
        check("w11", {Warn, Count}, 32'h011);
        cyc(4);
        check("w10", {Warn, Count}, 32'h110);
        cyc(36);
        check("w01", {Warn, Count}, 32'h101);
        cyc(4);
        check("w_exp", {Warn, Expired, Count}, 32'h100);
`endif

        // Randomised stimulus against the model.
        for (int c = 0; c < 4000; c++) begin
            Reset = ($urandom_range(0, 499) == 0);
            Load  = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 3) == 0) LoadValue = LW'($urandom);
            else LoadValue = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 15) == 0) Pause = ~Pause;
            Start = ($urandom_range(0, 3) == 0);
            cyc(1);
        end

        Reset = 1'b0; Load = 1'b0; Pause = 1'b0; Start = 1'b0;
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_countdown_timer.md
Name: game_countdown_timer

Overview:
- Parametrised BCD countdown timer for the game's time-left display; successor to the fixed 2-digit up-counter.
- Generalised digit count and tick period. Adds start, pause, load, expiry, and a run-state FSM.
- Sits between the board clock and the per-digit hex decoders. Its expiry output ends a game round in the game-control FSM.

Parameters:
- CLOCK_FREQUENCY, 50000000: ClockIn cycles per count step (1 s at 50 MHz); must be >= 2.
- NUM_DIGITS, 2: number of BCD digits; range 1..6.
- START_VALUE, 60: decimal value loaded on reset; must be < 10**NUM_DIGITS.
- WARN_THRESHOLD, 10: decimal warning level; used only with TIMER_WARN_EN.

Ports:
- ClockIn  in  1  system clock (CLOCK_50 at top).
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  level; start or resume counting.
- Pause  in  1  level; freeze counting.
- Load  in  1  level; load LoadValue and go idle.
- LoadValue  in  4*NUM_DIGITS  BCD value; digit 0 in [3:0].
- Count  out  4*NUM_DIGITS  registered BCD time remaining; digit 0 in [3:0].
- Running  out  1  high in RUN.
- Expired  out  1  high in EXPIRED.
- ExpirePulse  out  1  one-cycle pulse on entry to EXPIRED.
- SecondTick  out  1  one-cycle pulse in the cycle Count shows a decremented value.
- Warn  out  1  warning flag (see Optional Feature).

Behaviour:
- Synchronous reset, active-high, checked on posedge ClockIn.
  - Reset: state=IDLE; Count=BCD(START_VALUE); divider=CLOCK_FREQUENCY-1.
  - All 1-bit outputs are 0 after reset.
- Divider: down-counter of width $clog2(CLOCK_FREQUENCY).
  - Decrements only in RUN.
  - On reaching 0 in RUN it reloads CLOCK_FREQUENCY-1 and fires an internal step.
- Control priority each cycle: Reset > Load > Pause > Start.
- Load (any state):
  - Count <= LoadValue, with any digit >9 clamped to 9.
  - state=IDLE; divider reloaded; Expired=0.
- FSM states: IDLE, RUN, PAUSED, EXPIRED.
  - IDLE + Start, Count!=0 -> RUN. Divider reloaded, so the first step lands exactly CLOCK_FREQUENCY cycles after the Start cycle.
  - IDLE + Start, Count==0 -> EXPIRED; ExpirePulse next cycle.
  - RUN + Pause -> PAUSED. Divider holds its value.
  - PAUSED + Start (Pause low) -> RUN. Divider resumes from the held value, so no partial second is lost.
  - RUN + step:
    - Count decremented as BCD with borrow: digit 0 wraps 0->9 and borrows from the next digit.
    - SecondTick=1 in the same cycle the new Count appears.
    - If the new Count==0: state -> EXPIRED; ExpirePulse=1 and Expired=1 in that same cycle.
  - EXPIRED: Count holds 0; Start and Pause ignored. Leave only via Load or Reset.
  - Ignored inputs: Start in RUN; Pause in IDLE or EXPIRED.
- Running, Expired and ExpirePulse are registered outputs, aligned with Count.
- Simultaneous Pause and step in the same cycle: Pause wins; no decrement; divider holds 0.
  - On resume, the step fires on the first RUN cycle.
- Reset or Load in mid-run aborts the current second immediately; no SecondTick or ExpirePulse is issued.

Optional Feature:
- Macro: TIMER_WARN_EN.
- Defined:
  - Warn is registered.
  - Warn=1 when state is RUN or PAUSED and decimal(Count) <= WARN_THRESHOLD.
  - Warn=0 in IDLE and EXPIRED, and 0 after reset.
  - The comparison is done on the BCD digits directly; no binary conversion.
- Undefined:
  - Warn port still present and tied to 0.
  - No comparison logic is synthesised.

Test Plan:
- CLOCK_FREQUENCY=4, NUM_DIGITS=2, START_VALUE=60; Reset, then Start pulse -> Count 0x60 for 4 cycles. Then 0x59 with SecondTick=1 for one cycle; 0x58 four cycles later.
- Load LoadValue=0x10, then Start -> Count steps 0x10 -> 0x09 (borrow); 0x01 -> 0x00 with ExpirePulse=1 for one cycle. Expired stays 1; further Start leaves Count=0x00.
- Run from 0x60; Pause asserted 2 cycles into a second and held 20 cycles; then Start -> Count unchanged during pause. Next decrement lands 2 cycles after resume.
- Load with LoadValue=0xAF -> Count=0x99 (clamped), state IDLE, Running=0. Load and Start asserted together -> Load wins, Running=0.
- Count 0x00, Start -> Expired=1 and ExpirePulse=1 the next cycle. Reset mid-run -> Count=0x60 and all flags 0 on the next cycle.
- With TIMER_WARN_EN, WARN_THRESHOLD=10, running from 0x12 -> Warn rises the cycle Count=0x10 and stays high to 0x01. Warn drops to 0 when EXPIRED is entered.
